nabp_state_control_multi: RTL
=============================

# nabp_state_control_multi

Parametrised successor of the NABP per-iteration state controller. It sequences a full projection run of `NUM_ITR` iterations without per-iteration supervision. It provides fill/shift handshakes with the swap control and the shifter, and captures each iteration's angle and line-count factor for the mapper. Over the single-iteration controller it adds:
- start/done run control with an iteration counter;
- a watchdog timeout on shifter phases;
- abort.

## Interface
- `ANGLE_W`, 9, width of angle values.
- `FACT_W`, 16, width of the fixed-point line-count factor (two's complement, passed through unaltered).
- `NUM_ITR`, 180, iterations per run; must be ≥1.
- `TIMEOUT`, 1024, watchdog limit in cycles for `FILL`/`SHIFT`; 0 disables the watchdog.
- `ITR_W`, clog2(`NUM_ITR`+1), width of `itr_cnt`.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  pulse: begin a run from `IDLE`; in `ERROR`, clears the error.
- `abort`  in  1  level: return to `IDLE` from any state.
- `sw_angle`  in  `ANGLE_W`  next iteration angle from swap control.
- `sw_line_cnt_fact`  in  `FACT_W`  next iteration line-count factor.
- `sw_swap`  in  1  swap control grants the swap.
- `sh_fill_done`  in  1  shifter fill complete.
- `sh_shift_done`  in  1  shifter shift complete.
- `mp_angle`  out  `ANGLE_W`  angle of the current iteration.
- `mp_line_cnt_fact`  out  `FACT_W`  factor of the current iteration.
- `mp_valid`  out  1  `mp_*` hold a captured iteration.
- `sw_next_itr`  out  1  request the next iteration's data (Mealy pulse).
- `sw_swap_ready`  out  1  fill complete, awaiting swap.
- `sh_fill_kick`  out  1  start fill (Mealy pulse).
- `sh_shift_kick`  out  1  start shift (Mealy pulse).
- `itr_cnt`  out  `ITR_W`  completed iterations in this run.
- `busy`  out  1  state not `IDLE`/`ERROR`.
- `done`  out  1  one-cycle pulse: run completed.
- `timeout_err`  out  1  sticky watchdog error.

## Operation
States: `IDLE`, `SETUP`, `FILL`, `FILL_DONE`, `SHIFT`, `SHIFT_DONE`, `DONE`, `ERROR`. Transition priority is `reset` > `abort` > watchdog > normal.

Normal transitions:
- `IDLE` → `SETUP` on `start`.
- `SETUP` → `FILL` unconditionally.
- `FILL` → `FILL_DONE` on `sh_fill_done`.
- `FILL_DONE` → `SHIFT` on `sw_swap`.
- `SHIFT` → `SHIFT_DONE` on `sh_shift_done`.
- `SHIFT_DONE` → `DONE` if `itr_cnt`+1 == `NUM_ITR`, else → `SETUP`.
- `DONE` → `IDLE`.

Outputs:
- `sw_next_itr` = (`IDLE` & `start` & !`abort`) | (`SHIFT_DONE` & not last & !`abort`).
- `sh_fill_kick` = `SETUP` & !`abort`.
- `sh_shift_kick` = `FILL_DONE` & `sw_swap` & !`abort`.
- `sw_swap_ready` = `FILL_DONE`.
- `done` = `DONE`.
- `busy` = state ∉ {`IDLE`, `ERROR`}.

Data capture and counting:
- At the clock edge leaving `SETUP`, register `sw_angle` and `sw_line_cnt_fact` into `mp_*` and set `mp_valid`.
- `mp_valid` clears on entering `IDLE` or `ERROR`. `mp_*` values hold until the next capture.
- `itr_cnt` clears on `start` accepted in `IDLE` and increments at the edge leaving `SHIFT_DONE`. It holds its final value (`NUM_ITR`) after `DONE` until the next `start`.

Watchdog (when `TIMEOUT` > 0):
- Counter zeroes on entry to `FILL` or `SHIFT` and increments each cycle spent in them.
- In the cycle it equals `TIMEOUT`-1 with the corresponding done input low, next state is `ERROR` and `timeout_err` sets.
- A done input in that same cycle wins; no error.
- `FILL_DONE` (waiting for swap) is never timed.

Error and abort:
- `ERROR` holds until `start`, which clears `timeout_err` and goes to `IDLE`. It does not begin a run.
- `abort` in any state → `IDLE` next cycle. It suppresses all Mealy pulses that cycle, gives no `done`, and leaves `itr_cnt` as-is.

Ignored inputs:
- `start` outside `IDLE`/`ERROR` is ignored.
- `sh_*_done` and `sw_swap` outside their waiting states are ignored.

## Timing
- Reset: state `IDLE`; all outputs 0, including `mp_angle`, `mp_line_cnt_fact`, `itr_cnt`, `timeout_err`, and the watchdog counter.
- `start` at cycle 0 (in `IDLE`): `sw_next_itr`=1 at cycle 0, `SETUP` with `sh_fill_kick`=1 at cycle 1, `FILL` and `mp_valid`=1 at cycle 2.
- Swap control must present valid `sw_*` during the `SETUP` cycle, one cycle after `sw_next_itr`.
- Minimum iteration time is 5 cycles (`SETUP`, `FILL`, `FILL_DONE`, `SHIFT`, `SHIFT_DONE`), with done/swap inputs high on first sample.
- `done` follows the final `SHIFT_DONE` by one cycle.

## Test plan
- `NUM_ITR`=3, shifter and swap respond immediately, angles 10/20/30: exactly 3 `sw_next_itr`/`sh_fill_kick`/`sh_shift_kick` pulses; `mp_angle` 10→20→30; `done` at cycle 16 after `start`; `itr_cnt`=3.
- `sw_swap` held low 50 cycles in `FILL_DONE` with `TIMEOUT`=8: `sw_swap_ready` stays 1, no error; shift kicks the cycle `sw_swap` rises.
- `TIMEOUT`=8, `sh_fill_done` never asserted: `ERROR` after 8 `FILL` cycles; `timeout_err`=1, `busy`=0, `mp_valid`=0; `start` clears it to `IDLE` with no kick.
- `sh_shift_done` asserted in the exact cycle the watchdog expires: goes to `SHIFT_DONE`, `timeout_err` stays 0.
- `abort` during `SHIFT` of iteration 2 (with `sh_shift_done`=1 the same cycle): `IDLE` next cycle, no `done`, `itr_cnt`=1; subsequent `start` runs cleanly from 0.
- `reset` asserted mid-`FILL` coincident with `sh_fill_done`: next cycle all outputs 0, state `IDLE`; `start` during reset is ignored.

Source files
------------

// File: rtl/nabp_state_control_multi_if.sv
// Handshake bundle between the multi-iteration state controller, swap control,
// the shifter and the mapper. The controller connects through the master modport.
interface nabp_state_control_multi_if #(
    parameter int unsigned ANGLE_W = 9,
    parameter int unsigned FACT_W  = 16
);
    // Swap control side
    logic [ANGLE_W-1:0] sw_angle;
    logic [FACT_W-1:0]  sw_line_cnt_fact;
    logic               sw_swap;
    logic               sw_next_itr;
    logic               sw_swap_ready;

    // Shifter side
    logic               sh_fill_done;
    logic               sh_shift_done;
    logic               sh_fill_kick;
    logic               sh_shift_kick;

    // Mapper side
    logic [ANGLE_W-1:0] mp_angle;
    logic [FACT_W-1:0]  mp_line_cnt_fact;
    logic               mp_valid;

    modport master (
        input  sw_angle,
        input  sw_line_cnt_fact,
        input  sw_swap,
        input  sh_fill_done,
        input  sh_shift_done,
        output sw_next_itr,
        output sw_swap_ready,
        output sh_fill_kick,
        output sh_shift_kick,
        output mp_angle,
        output mp_line_cnt_fact,
        output mp_valid
    );

    modport slave (
        output sw_angle,
        output sw_line_cnt_fact,
        output sw_swap,
        output sh_fill_done,
        output sh_shift_done,
        input  sw_next_itr,
        input  sw_swap_ready,
        input  sh_fill_kick,
        input  sh_shift_kick,
        input  mp_angle,
        input  mp_line_cnt_fact,
        input  mp_valid
    );
endinterface

// File: rtl/nabp_state_control_multi.sv
// NABP state controller sequencing NUM_ITR projection iterations per run, with
// a watchdog on shifter phases, abort, and per-iteration angle/factor capture.
module nabp_state_control_multi #(
    parameter int unsigned ANGLE_W = 9,
    parameter int unsigned FACT_W  = 16,
    parameter int unsigned NUM_ITR = 180,
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned ITR_W   = $clog2(NUM_ITR + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        abort,
    nabp_state_control_multi_if.master  bus,
    output logic [ITR_W-1:0]            itr_cnt,
    output logic                        busy,
    output logic                        done,
    output logic                        timeout_err
);

    localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit          WD_EN = (TIMEOUT != 0);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [ITR_W:0]   ITR_LAST = (ITR_W + 1)'(NUM_ITR);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StFill,
        StFillDone,
        StShift,
        StShiftDone,
        StDone,
        StError
    } state_e;

    state_e             state_q, state_d;
    logic [ITR_W-1:0]   itr_cnt_q, itr_cnt_d;
    logic [WD_W-1:0]    wdog_q, wdog_d;
    logic               err_q, err_d;
    logic [ANGLE_W-1:0] angle_q;
    logic [FACT_W-1:0]  fact_q;
    logic               valid_q, valid_d;
    logic               capture;
    logic               last_itr;
    logic               wdog_exp;

    assign last_itr = (({1'b0, itr_cnt_q} + {{ITR_W{1'b0}}, 1'b1}) == ITR_LAST);
    assign wdog_exp = WD_EN && (wdog_q == WD_LAST);

    always_comb begin
        state_d           = state_q;
        itr_cnt_d         = itr_cnt_q;
        err_d             = err_q;
        wdog_d            = '0;
        capture           = 1'b0;
        bus.sw_next_itr   = 1'b0;
        bus.sh_fill_kick  = 1'b0;
        bus.sh_shift_kick = 1'b0;

        // Start in ERROR clears the error even when abort wins the transition.
        if (state_q == StError && start) begin
            err_d = 1'b0;
        end

        if (abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d         = StSetup;
                        itr_cnt_d       = '0;
                        bus.sw_next_itr = 1'b1;
                    end
                end
                StSetup: begin
                    state_d          = StFill;
                    capture          = 1'b1;
                    bus.sh_fill_kick = 1'b1;
                end
                StFill: begin
                    if (bus.sh_fill_done) begin
                        state_d = StFillDone;
                    end else if (wdog_exp) begin
                        state_d = StError;
                        err_d   = 1'b1;
                    end else begin
                        wdog_d = wdog_q + 1'b1;
                    end
                end
                StFillDone: begin
                    if (bus.sw_swap) begin
                        state_d           = StShift;
                        bus.sh_shift_kick = 1'b1;
                    end
                end
                StShift: begin
                    if (bus.sh_shift_done) begin
                        state_d = StShiftDone;
                    end else if (wdog_exp) begin
                        state_d = StError;
                        err_d   = 1'b1;
                    end else begin
                        wdog_d = wdog_q + 1'b1;
                    end
                end
                StShiftDone: begin
                    itr_cnt_d = itr_cnt_q + 1'b1;
                    if (last_itr) begin
                        state_d = StDone;
                    end else begin
                        state_d         = StSetup;
                        bus.sw_next_itr = 1'b1;
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                StError: begin
                    if (start) begin
                        state_d = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_comb begin
        valid_d = valid_q;
        if (capture) begin
            valid_d = 1'b1;
        end else if (state_d == StIdle || state_d == StError) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            itr_cnt_q <= '0;
            wdog_q    <= '0;
            err_q     <= 1'b0;
            angle_q   <= '0;
            fact_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            itr_cnt_q <= itr_cnt_d;
            wdog_q    <= wdog_d;
            err_q     <= err_d;
            valid_q   <= valid_d;
            if (capture) begin
                angle_q <= bus.sw_angle;
                fact_q  <= bus.sw_line_cnt_fact;
            end
        end
    end

    assign bus.sw_swap_ready    = (state_q == StFillDone);
    assign bus.mp_angle         = angle_q;
    assign bus.mp_line_cnt_fact = fact_q;
    assign bus.mp_valid         = valid_q;
    assign itr_cnt              = itr_cnt_q;
    assign busy                 = !(state_q == StIdle || state_q == StError);
    assign done                 = (state_q == StDone);
    assign timeout_err          = err_q;

endmodule
